// File: rtl/auto_corr_metric.sv
// Delay-and-correlate packet-detect front end: windowed autocorrelation P(n) at lag D
// and delayed-sample energy R(n), with saturated 24-bit magnitude, energy and complex P.
module auto_corr_metric #(
  parameter int DW    = 16,
  parameter int D     = 16,
  parameter int L     = 32,
  parameter int SHIFT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_i,
  input  logic signed [DW-1:0] in_q,
  output logic                 out_valid,
  output logic                 metric_valid,
  output logic        [23:0]   P_Metric_mag,
  output logic        [23:0]   R_Metric,
  output logic signed [23:0]   P_re,
  output logic signed [23:0]   P_im
);

  localparam int PW = 2 * DW + 1;
  localparam int LW = $clog2(L);
  localparam int AW = PW + LW;
  localparam int CW = $clog2(D + L + 1);

  logic clear;
  assign clear = rst | clr;

  // ---------------- delay line ----------------
  logic signed [DW-1:0] dl_i_reg [D];
  logic signed [DW-1:0] dl_q_reg [D];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int k = 0; k < D; k++) begin
        dl_i_reg[k] <= '0;
        dl_q_reg[k] <= '0;
      end
    end else if (in_valid) begin
      dl_i_reg[0] <= in_i;
      dl_q_reg[0] <= in_q;
      for (int k = 1; k < D; k++) begin
        dl_i_reg[k] <= dl_i_reg[k-1];
        dl_q_reg[k] <= dl_q_reg[k-1];
      end
    end
  end

  // ---------------- stage 1: x * conj(y), |y|^2 ----------------
  logic signed [PW-1:0] xi_e, xq_e, yi_e, yq_e;
  logic signed [PW-1:0] pr_c, pi_c, e_c;
  logic signed [PW-1:0] pr_reg, pi_reg, e_reg;
  logic                 v1_reg;

  // Operands are sign-extended first so the products are formed at full precision.
  assign xi_e = PW'(in_i);
  assign xq_e = PW'(in_q);
  assign yi_e = PW'(dl_i_reg[D-1]);
  assign yq_e = PW'(dl_q_reg[D-1]);
  assign pr_c = xi_e * yi_e + xq_e * yq_e;
  assign pi_c = xq_e * yi_e - xi_e * yq_e;
  assign e_c  = yi_e * yi_e + yq_e * yq_e;

  always_ff @(posedge clk) begin
    if (clear) begin
      v1_reg <= 1'b0;
      pr_reg <= '0;
      pi_reg <= '0;
      e_reg  <= '0;
    end else begin
      v1_reg <= in_valid;
      if (in_valid) begin
        pr_reg <= pr_c;
        pi_reg <= pi_c;
        e_reg  <= e_c;
      end
    end
  end

  // ---------------- stage 2: moving sums over L ----------------
  logic signed [PW-1:0] pr_h_reg [L];
  logic signed [PW-1:0] pi_h_reg [L];
  logic signed [PW-1:0] e_h_reg  [L];
  logic signed [AW-1:0] pre_reg, pim_reg, racc_reg;
  logic                 v2_reg;

  always_ff @(posedge clk) begin
    if (clear) begin
      v2_reg   <= 1'b0;
      pre_reg  <= '0;
      pim_reg  <= '0;
      racc_reg <= '0;
      for (int k = 0; k < L; k++) begin
        pr_h_reg[k] <= '0;
        pi_h_reg[k] <= '0;
        e_h_reg[k]  <= '0;
      end
    end else begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        pre_reg  <= pre_reg  + AW'(pr_reg) - AW'(pr_h_reg[L-1]);
        pim_reg  <= pim_reg  + AW'(pi_reg) - AW'(pi_h_reg[L-1]);
        racc_reg <= racc_reg + AW'(e_reg)  - AW'(e_h_reg[L-1]);
        pr_h_reg[0] <= pr_reg;
        pi_h_reg[0] <= pi_reg;
        e_h_reg[0]  <= e_reg;
        for (int k = 1; k < L; k++) begin
          pr_h_reg[k] <= pr_h_reg[k-1];
          pi_h_reg[k] <= pi_h_reg[k-1];
          e_h_reg[k]  <= e_h_reg[k-1];
        end
      end
    end
  end

  // ---------------- stage 3: magnitude, scaling, saturation ----------------
  function automatic logic [23:0] sat_u(input logic [AW:0] v);
    if (|v[AW:24]) return 24'hFF_FFFF;
    return v[23:0];
  endfunction

  function automatic logic [23:0] sat_s(input logic signed [AW-1:0] v);
    if (v[AW-1:23] == '0 || v[AW-1:23] == '1) return v[23:0];
    if (v[AW-1]) return 24'h80_0000;
    return 24'h7F_FFFF;
  endfunction

  // Absolute values are unsigned AW bits, so the most-negative input maps to 2^(AW-1).
  logic        [AW-1:0] pre_abs, pim_abs;
  logic        [AW:0]   mag_sum, mag_sh;
  logic signed [AW-1:0] pre_sh, pim_sh, r_sh;

  assign pre_abs = pre_reg[AW-1] ? $unsigned(-pre_reg) : $unsigned(pre_reg);
  assign pim_abs = pim_reg[AW-1] ? $unsigned(-pim_reg) : $unsigned(pim_reg);
  assign mag_sum = {1'b0, pre_abs} + {1'b0, pim_abs};
  assign mag_sh  = mag_sum >> SHIFT;
  assign pre_sh  = pre_reg >>> SHIFT;
  assign pim_sh  = pim_reg >>> SHIFT;
  assign r_sh    = racc_reg >>> SHIFT;

  logic          out_valid_reg, metric_valid_reg;
  logic [23:0]   mag_reg, r_out_reg, pre_out_reg, pim_out_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (clear) begin
      out_valid_reg    <= 1'b0;
      metric_valid_reg <= 1'b0;
      cnt_reg          <= '0;
      mag_reg          <= '0;
      r_out_reg        <= '0;
      pre_out_reg      <= '0;
      pim_out_reg      <= '0;
    end else begin
      out_valid_reg <= v2_reg;
      if (v2_reg) begin
        mag_reg     <= sat_u(mag_sh);
        r_out_reg   <= sat_u({1'b0, $unsigned(r_sh)});
        pre_out_reg <= sat_s(pre_sh);
        pim_out_reg <= sat_s(pim_sh);
        if (cnt_reg < CW'(D + L)) cnt_reg <= cnt_reg + 1'b1;
        // The (D+L)-th sample is the first whose window holds only real delayed samples.
        if (cnt_reg == CW'(D + L - 1)) metric_valid_reg <= 1'b1;
      end
    end
  end

  assign out_valid    = out_valid_reg;
  assign metric_valid = metric_valid_reg;
  assign P_Metric_mag = mag_reg;
  assign R_Metric     = r_out_reg;
  assign P_re         = pre_out_reg;
  assign P_im         = pim_out_reg;

endmodule

// File: tb/tb_auto_corr_metric.sv
// Scoreboard bench for auto_corr_metric: a software model predicts every output tuple
// at drive time; a negedge monitor pops and compares when out_valid strobes.
module tb_auto_corr_metric;
  localparam int DW = 16, D = 16, L = 32, SHIFT = 8;

  logic clk = 1'b0, rst = 1'b1, clr = 1'b0, in_valid = 1'b0;
  logic signed [DW-1:0] in_i = '0, in_q = '0;
  logic out_valid, metric_valid;
  logic [23:0] P_Metric_mag, R_Metric;
  logic signed [23:0] P_re, P_im;

  auto_corr_metric #(.DW(DW), .D(D), .L(L), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
    .out_valid(out_valid), .metric_valid(metric_valid), .P_Metric_mag(P_Metric_mag),
    .R_Metric(R_Metric), .P_re(P_re), .P_im(P_im)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint mag, r, pre, pim, mv, cyc;
  } tup_t;

  tup_t sb[$];
  tup_t cap[$];
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  longint m_di[D], m_dq[D], m_hr[L], m_hi[L], m_he[L];
  longint m_pre, m_pim, m_r;
  int m_cnt;

  function automatic void model_reset();
    for (int k = 0; k < D; k++) begin m_di[k] = 0; m_dq[k] = 0; end
    for (int k = 0; k < L; k++) begin m_hr[k] = 0; m_hi[k] = 0; m_he[k] = 0; end
    m_pre = 0; m_pim = 0; m_r = 0; m_cnt = 0;
  endfunction

  function automatic longint abs64(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic longint sat_u24(input longint v);
    return (v > 16777215) ? 16777215 : v;
  endfunction

  function automatic longint sat_s24(input longint v);
    if (v > 8388607) return 8388607;
    if (v < -8388608) return -8388608;
    return v;
  endfunction

  function automatic tup_t model_step(input longint xi, input longint xq);
    tup_t t;
    longint yi, yq, pr, pi, e;
    yi = m_di[D-1]; yq = m_dq[D-1];
    for (int k = D - 1; k > 0; k--) begin m_di[k] = m_di[k-1]; m_dq[k] = m_dq[k-1]; end
    m_di[0] = xi; m_dq[0] = xq;
    pr = xi * yi + xq * yq;
    pi = xq * yi - xi * yq;
    e  = yi * yi + yq * yq;
    m_pre += pr - m_hr[L-1];
    m_pim += pi - m_hi[L-1];
    m_r   += e  - m_he[L-1];
    for (int k = L - 1; k > 0; k--) begin
      m_hr[k] = m_hr[k-1]; m_hi[k] = m_hi[k-1]; m_he[k] = m_he[k-1];
    end
    m_hr[0] = pr; m_hi[0] = pi; m_he[0] = e;
    if (m_cnt < D + L) m_cnt++;
    t.mag = sat_u24((abs64(m_pre) + abs64(m_pim)) >>> SHIFT);
    t.r   = sat_u24(m_r >>> SHIFT);
    t.pre = sat_s24(m_pre >>> SHIFT);
    t.pim = sat_s24(m_pim >>> SHIFT);
    t.mv  = (m_cnt == D + L) ? 1 : 0;
    t.cyc = 0;
    return t;
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input int i, input int q, input bit c, input bit r);
    tup_t t;
    in_valid = v; in_i = DW'(i); in_q = DW'(q); clr = c; rst = r;
    if (v && !c && !r) begin
      t = model_step(longint'(i), longint'(q));
      t.cyc = cyc + 3;
      sb.push_back(t);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; clr = 1'b0; rst = 1'b0;
    if (c || r) begin
      sb.delete();
      cap.delete();
      model_reset();
      chk("clr_out_valid", longint'(out_valid), 0);
      chk("clr_metric_valid", longint'(metric_valid), 0);
      chk("clr_mag", longint'(P_Metric_mag), 0);
      chk("clr_r", longint'(R_Metric), 0);
      chk("clr_pre", longint'(P_re), 0);
      chk("clr_pim", longint'(P_im), 0);
    end
  endtask

  task automatic drain();
    repeat (6) drive(0, 0, 0, 0, 0);
    chk("drain_empty", longint'(sb.size()), 0);
  endtask

  function automatic int rnd(input real x);
    return $rtoi(x >= 0.0 ? x + 0.5 : x - 0.5);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      tup_t o, e;
      o.mag = longint'(P_Metric_mag);
      o.r   = longint'(R_Metric);
      o.pre = longint'(P_re);
      o.pim = longint'(P_im);
      o.mv  = longint'(metric_valid);
      o.cyc = cyc;
      cap.push_back(o);
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("mag", o.mag, e.mag);
        chk("r", o.r, e.r);
        chk("pre", o.pre, e.pre);
        chk("pim", o.pim, e.pim);
        chk("metric_valid", o.mv, e.mv);
        chk("latency_cycle", o.cyc, e.cyc);
      end
    end
  end

  int ri[80], rq[80];
  tup_t run_a[$];

  initial begin
    model_reset();
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);

    // constant 1024 + j0
    for (int n = 0; n < 60; n++) drive(1, 1024, 0, 0, 0);
    drain();
    chk("const_mag", longint'(P_Metric_mag), 131072);
    chk("const_r", longint'(R_Metric), 131072);
    chk("const_pre", longint'(P_re), 131072);
    chk("const_pim", longint'(P_im), 0);
    chk("const_mv", longint'(metric_valid), 1);

    // sign flip every D samples
    drive(0, 0, 0, 1, 0);
    for (int n = 0; n < 80; n++) drive(1, ((n / 16) % 2 == 1) ? -1024 : 1024, 0, 0, 0);
    drain();
    chk("flip_pre", longint'(P_re), -131072);
    chk("flip_pim", longint'(P_im), 0);
    chk("flip_mag", longint'(P_Metric_mag), 131072);
    chk("flip_r", longint'(R_Metric), 131072);

    // rotator, 90 degrees per lag
    drive(0, 0, 0, 1, 0);
    for (int n = 0; n < 80; n++)
      drive(1, rnd(1024.0 * $cos(3.14159265358979 * n / 32.0)),
            rnd(1024.0 * $sin(3.14159265358979 * n / 32.0)), 0, 0);
    drain();
    chk("rot_pre_tol", longint'(abs64(longint'(P_re)) <= 1310), 1);
    chk("rot_pim_tol", longint'(abs64(longint'(P_im) - 131072) <= 1310), 1);
    chk("rot_mag_vs_r",
        longint'(abs64(longint'(P_Metric_mag) - longint'(R_Metric)) * 100 <= longint'(R_Metric)), 1);

    // full scale
    drive(0, 0, 0, 1, 0);
    for (int n = 0; n < 70; n++) drive(1, 32767, 32767, 0, 0);
    drain();
    chk("fs_mag", longint'(P_Metric_mag), 16777215);
    chk("fs_r", longint'(R_Metric), 16777215);
    chk("fs_pre", longint'(P_re), 8388607);
    chk("fs_pim", longint'(P_im), 0);

    // random samples: gapless, then gapped
    for (int n = 0; n < 80; n++) begin
      ri[n] = int'($urandom_range(0, 65535)) - 32768;
      rq[n] = int'($urandom_range(0, 65535)) - 32768;
    end
    ri[5] = -32768; rq[5] = -32768;
    drive(0, 0, 0, 1, 0);
    for (int n = 0; n < 80; n++) drive(1, ri[n], rq[n], 0, 0);
    drain();
    run_a = cap;
    drive(0, 0, 0, 1, 0);
    for (int n = 0; n < 80; n++) begin
      repeat ($urandom_range(0, 2)) drive(0, 0, 0, 0, 0);
      drive(1, ri[n], rq[n], 0, 0);
    end
    drain();
    chk("gap_count", longint'(cap.size()), longint'(run_a.size()));
    for (int n = 0; n < cap.size() && n < run_a.size(); n++) begin
      chk("gap_mag", cap[n].mag, run_a[n].mag);
      chk("gap_r", cap[n].r, run_a[n].r);
      chk("gap_pre", cap[n].pre, run_a[n].pre);
      chk("gap_pim", cap[n].pim, run_a[n].pim);
      chk("gap_mv", cap[n].mv, run_a[n].mv);
    end

    // clr at sample 30 (sample dropped), then re-warm-up
    for (int n = 0; n < 29; n++) drive(1, ri[n], rq[n], 0, 0);
    drive(1, 500, -300, 1, 0);
    for (int n = 0; n < 48; n++) drive(1, 1024, 0, 0, 0);
    drain();
    chk("clr_rewarm_mv", longint'(metric_valid), 1);
    chk("clr_rewarm_mag", longint'(P_Metric_mag), 131072);
    chk("clr_rewarm_pim", longint'(P_im), 0);

    // rst at sample 60
    for (int n = 0; n < 59; n++) drive(1, rq[n], ri[n], 0, 0);
    drive(1, 700, 700, 0, 1);
    for (int n = 0; n < 47; n++) drive(1, 1024, 0, 0, 0);
    drain();
    chk("rst_47_mv", longint'(metric_valid), 0);
    drive(1, 1024, 0, 0, 0);
    drain();
    chk("rst_48_mv", longint'(metric_valid), 1);
    chk("rst_rewarm_r", longint'(R_Metric), 131072);
    chk("rst_rewarm_pre", longint'(P_re), 131072);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/auto_corr_metric.md
Name: auto_corr_metric

Overview:
- Delay-and-correlate front end for packet detection on the short training field (Schmidl-Cox style).
- Computes the windowed autocorrelation P(n) = sum over L of r[k]·conj(r[k-D]) and the window energy R(n) = sum over L of |r[k-D]|^2.
- Outputs |P| (approximated), R, and the complex P (for the CFO estimator), all in 24-bit form.
- Sits directly upstream of the coarse time-sync stage, which consumes P_Metric_mag and R_Metric.

Parameters:
- DW, 16: input I/Q sample width, signed.
- D, 16: correlation lag in samples (STF period).
- L, 32: moving-sum window length; power of two, minimum 2.
- SHIFT, 8: arithmetic right shift applied to the accumulators before 24-bit saturation.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- clr  in  1  synchronous burst clear; same effect as rst on datapath state
- in_valid  in  1  sample strobe; the datapath advances only on samples with in_valid=1
- in_i  in  DW  sample real part, signed
- in_q  in  DW  sample imaginary part, signed
- out_valid  out  1  one-cycle strobe; outputs updated this cycle
- metric_valid  out  1  high once the delay line and window are full of real samples
- P_Metric_mag  out  24  unsigned, sat(( |Pre|+|Pim| ) >> SHIFT)
- R_Metric  out  24  unsigned, sat(Racc >> SHIFT)
- P_re  out  24  signed, sat(Pre >> SHIFT)
- P_im  out  24  signed, sat(Pim >> SHIFT)

Behaviour:
- Delay line: D-deep register chain of {in_i,in_q}. Shifts only on in_valid. Reset/clr value 0.
- Stage 1 (registered), on valid; x = current sample, y = sample D valid strobes earlier:
  - pr = xi·yi + xq·yq
  - pi = xq·yi − xi·yq
  - e = yi² + yq²
  - Full precision 2·DW+1 bits; no truncation.
- Stage 2 (registered): L-deep history of {pr,pi,e}, advanced only with a valid stage-1 word.
  - Pre += pr − pr_old; Pim += pi − pi_old; Racc += e − e_old.
  - Accumulator width 2·DW+1+log2(L); must never overflow.
  - History and accumulators reset to 0, so warm-up sums are exact partial sums.
- Stage 3 (registered):
  - Magnitude = |Pre| + |Pim|, with |x| of the most-negative value computed without wrap.
  - Arithmetic shift by SHIFT.
  - Unsigned outputs saturate to 16777215.
  - Signed outputs saturate to [-8388608, 8388607].
- Latency: in_valid at cycle t → out_valid at t+3.
  - The valid pipeline advances every clock; data stages are enabled by their valid bits.
  - Outputs hold their value between strobes.
- metric_valid:
  - An internal counter counts valid samples and saturates at D+L.
  - metric_valid rises with the out_valid of the (D+L)-th valid sample after reset/clr.
  - It stays high until rst or clr.
- rst or clr (either, any time, including mid-burst):
  - Next cycle: all delay/history/accumulator/pipeline-valid state = 0; out_valid=0, metric_valid=0.
  - All four metric outputs = 0.
  - Samples in flight are discarded.
- clr and in_valid in the same cycle: clr wins; the sample is dropped.
- Gapped in_valid produces output values identical to a gapless stream; only timing differs.
- No backpressure: the downstream stage must accept every out_valid.

Test Plan:
- Constant in_i=1024, in_q=0, defaults, continuous valid:
  - metric_valid rises on the 48th out_valid.
  - Then P_Metric_mag=R_Metric=P_re=131072, P_im=0.
  - Out_valid is 3 cycles after each in_valid.
- Input sign-inverted every 16 samples (±1024, Q=0):
  - After warm-up, P_re=−131072, P_im=0, P_Metric_mag=131072, R_Metric=131072.
- Rotator r[n]=1024·e^{jπn/32} (90° per D), quantised:
  - After warm-up, |P_re| ≤ 1% of 131072.
  - P_im within 131072 ±1%.
  - P_Metric_mag within 1% of R_Metric.
- Full scale in_i=in_q=32767 constant:
  - P_Metric_mag=R_Metric=16777215.
  - P_re=8388607, P_im=0.
  - No wrap at any later sample.
- Random stimulus with random in_valid gaps vs. the same samples gapless:
  - Sequence of output tuples at out_valid is identical.
  - Every output matches a bit-exact software model.
- Assert clr at sample 30 (and separately rst at sample 60):
  - Next cycle all outputs are 0 and metric_valid=0.
  - Re-warm-up takes exactly 48 new valid samples.
  - No pre-clear data contributes afterwards.
